// File: rtl/timer_seq_pkg.sv
// timer_seq_pkg
//   Shared definitions for the timer sequencer: FSM state encoding, BCD
//   time width, BCD digit check and the power-on preset program.
package timer_seq_pkg;

   localparam int TIME_W = 16;   // BCD {min1,min0,sec1,sec0}

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_SETTLE,
      S_RUN,
      S_BUZZ,
      S_NEXT,
      S_DONE
   } seq_state_e;

   // True when every nibble is a legal BCD digit (0..9).
   function automatic logic bcd_valid(input logic [TIME_W-1:0] v);
      logic ok;
      ok = 1'b1;
      for (int n = 0; n < TIME_W / 4; n++) begin
         if (v[n*4 +: 4] > 4'd9) ok = 1'b0;
      end
      return ok;
   endfunction

   // Default program: 05:00 / 01:00 alternating, unused slots empty.
   function automatic logic [TIME_W-1:0] preset_default(input int idx);
      case (idx)
         0, 2:    return 16'h0500;
         1, 3:    return 16'h0100;
         default: return 16'h0000;
      endcase
   endfunction

endpackage

// File: rtl/seq_preset_table.sv
// seq_preset_table
//   Preset slot storage. Loads the default program on reset; a write is
//   taken only when the address is in range and every digit is valid BCD.
//   Two combinational read ports: current slot and the slot after it.
// Ports:
//   clkin, rst_n          clock / async active-low reset
//   we_i, waddr_i, wdata_i write request (already gated by the FSM state)
//   raddr_a_i/rdata_a_o   read port A
//   raddr_b_i/rdata_b_o   read port B (out-of-range reads return 00:00)
module seq_preset_table
   import timer_seq_pkg::*;
#(
   parameter int NUM_SLOTS = 4,
   parameter int AW        = 2
) (
   input  logic              clkin,
   input  logic              rst_n,
   input  logic              we_i,
   input  logic [AW-1:0]     waddr_i,
   input  logic [TIME_W-1:0] wdata_i,
   input  logic [AW-1:0]     raddr_a_i,
   output logic [TIME_W-1:0] rdata_a_o,
   input  logic [AW-1:0]     raddr_b_i,
   output logic [TIME_W-1:0] rdata_b_o
);

   logic [TIME_W-1:0] tbl_q [NUM_SLOTS];

   always_ff @(posedge clkin or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_SLOTS; i++) tbl_q[i] <= preset_default(i);
      end else if (we_i && (int'(waddr_i) < NUM_SLOTS) && bcd_valid(wdata_i)) begin
         tbl_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_a_o = (int'(raddr_a_i) < NUM_SLOTS) ? tbl_q[raddr_a_i] : '0;
   assign rdata_b_o = (int'(raddr_b_i) < NUM_SLOTS) ? tbl_q[raddr_b_i] : '0;

endmodule

// File: rtl/timer_sequencer.sv
// timer_sequencer
//   Steps a countdown datapath through a table of preset times, buzzing at
//   the end of each slot and repeating the program ROUNDS times.
// Ports:
//   clkin, rst_n                      clock / async active-low reset
//   start_p, abort_p, skip_p, pause_p single-cycle button pulses
//   tmr_done                          datapath reached 00:00 (level)
//   cfg_we, cfg_addr, cfg_data        preset write (IDLE/DONE only)
//   ld_en, ld_time                    load strobe and BCD value to datapath
//   run                               datapath count enable
//   slot_idx, round_cnt               current slot / completed rounds
//   buzz, busy                        end-of-slot alert / sequence active
module timer_sequencer
   import timer_seq_pkg::*;
#(
   parameter int NUM_SLOTS = 4,
   parameter int ROUNDS    = 3,
   parameter int BUZZ_CYC  = 50000000,
   localparam int AW       = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1
) (
   input  logic              clkin,
   input  logic              rst_n,
   input  logic              start_p,
   input  logic              abort_p,
   input  logic              skip_p,
   input  logic              pause_p,
   input  logic              tmr_done,
   input  logic              cfg_we,
   input  logic [AW-1:0]     cfg_addr,
   input  logic [TIME_W-1:0] cfg_data,
   output logic              ld_en,
   output logic [TIME_W-1:0] ld_time,
   output logic              run,
   output logic [AW-1:0]     slot_idx,
   output logic [3:0]        round_cnt,
   output logic              buzz,
   output logic              busy
);

   localparam int BW = $clog2(BUZZ_CYC + 1);

   seq_state_e        state_q, state_d;
   logic [AW-1:0]     slot_q, slot_d;
   logic [3:0]        round_q, round_d;
   logic              run_q, run_d;
   logic              buzz_q, buzz_d;
   logic              ld_en_q, ld_en_d;
   logic [TIME_W-1:0] ld_time_q, ld_time_d;
   logic              busy_q, busy_d;
   logic [BW-1:0]     cnt_q, cnt_d;
   logic              tmr_q;

   logic [TIME_W-1:0] cur_time, nxt_time;
   logic [AW-1:0]     slot_nxt;
   logic              tmr_edge;
   logic              last_slot;

   assign slot_nxt  = slot_q + AW'(1);
   assign tmr_edge  = tmr_done & ~tmr_q;
   assign last_slot = (int'(slot_q) == NUM_SLOTS - 1);

   seq_preset_table #(
      .NUM_SLOTS (NUM_SLOTS),
      .AW        (AW)
   ) u_tbl (
      .clkin     (clkin),
      .rst_n     (rst_n),
      .we_i      (cfg_we && (state_q == S_IDLE || state_q == S_DONE)),
      .waddr_i   (cfg_addr),
      .wdata_i   (cfg_data),
      .raddr_a_i (slot_q),
      .rdata_a_o (cur_time),
      .raddr_b_i (slot_nxt),
      .rdata_b_o (nxt_time)
   );

   always_comb begin
      state_d   = state_q;
      slot_d    = slot_q;
      round_d   = round_q;
      run_d     = run_q;
      buzz_d    = buzz_q;
      ld_en_d   = 1'b0;
      ld_time_d = ld_time_q;
      cnt_d     = cnt_q;

      if (abort_p) begin
         // slot/round are deliberately kept so the user can see where it stopped
         state_d = S_IDLE;
         run_d   = 1'b0;
         buzz_d  = 1'b0;
      end else begin
         case (state_q)
            S_IDLE, S_DONE: begin
               if (start_p) begin
                  slot_d  = '0;
                  round_d = '0;
                  state_d = S_LOAD;
               end
            end
            S_LOAD: begin
               if (cur_time == '0) begin
                  // empty first slot means there is no program at all
                  state_d = (slot_q == '0) ? S_DONE : S_NEXT;
               end else begin
                  ld_en_d   = 1'b1;
                  ld_time_d = cur_time;
                  state_d   = S_SETTLE;
               end
            end
            S_SETTLE: begin
               // gives the datapath a cycle to take the load before counting
               run_d   = 1'b1;
               state_d = S_RUN;
            end
            S_RUN: begin
               if (skip_p) begin
                  run_d   = 1'b0;
                  state_d = S_NEXT;
               end else if (tmr_edge) begin
                  run_d   = 1'b0;
                  buzz_d  = 1'b1;
                  cnt_d   = BW'(BUZZ_CYC - 1);
                  state_d = S_BUZZ;
               end else if (pause_p) begin
                  run_d = ~run_q;
               end
            end
            S_BUZZ: begin
               if (skip_p || cnt_q == '0) begin
                  buzz_d  = 1'b0;
                  state_d = S_NEXT;
               end else begin
                  cnt_d = cnt_q - BW'(1);
               end
            end
            S_NEXT: begin
               // an empty slot terminates the round early
               if (last_slot || nxt_time == '0) begin
                  slot_d  = '0;
                  round_d = (round_q == 4'd15) ? 4'd15 : round_q + 4'd1;
                  state_d = ((int'(round_q) + 1) == ROUNDS) ? S_DONE : S_LOAD;
               end else begin
                  slot_d  = slot_nxt;
                  state_d = S_LOAD;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end

      busy_d = (state_d != S_IDLE) && (state_d != S_DONE);
   end

   always_ff @(posedge clkin or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         slot_q    <= '0;
         round_q   <= '0;
         run_q     <= 1'b0;
         buzz_q    <= 1'b0;
         ld_en_q   <= 1'b0;
         ld_time_q <= '0;
         busy_q    <= 1'b0;
         cnt_q     <= '0;
         tmr_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         slot_q    <= slot_d;
         round_q   <= round_d;
         run_q     <= run_d;
         buzz_q    <= buzz_d;
         ld_en_q   <= ld_en_d;
         ld_time_q <= ld_time_d;
         busy_q    <= busy_d;
         cnt_q     <= cnt_d;
         tmr_q     <= tmr_done;
      end
   end

   assign ld_en     = ld_en_q;
   assign ld_time   = ld_time_q;
   assign run       = run_q;
   assign slot_idx  = slot_q;
   assign round_cnt = round_q;
   assign buzz      = buzz_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_timer_sequencer.sv
// tb_timer_sequencer
//   Directed bench: a vector table for the first program steps, then
//   hand-written sequences for full programs, table writes and reset.
module tb_timer_sequencer;

   logic        clkin = 1'b0;
   logic        rst_n = 1'b0;
   logic        start_p = 1'b0, abort_p = 1'b0, skip_p = 1'b0, pause_p = 1'b0;
   logic        tmr_done = 1'b0;
   logic        cfg_we = 1'b0;
   logic [1:0]  cfg_addr = '0;
   logic [15:0] cfg_data = '0;
   logic        ld_en, run, buzz, busy;
   logic [15:0] ld_time;
   logic [1:0]  slot_idx;
   logic [3:0]  round_cnt;

   timer_sequencer #(.NUM_SLOTS(4), .ROUNDS(3), .BUZZ_CYC(4)) dut (
      .clkin(clkin), .rst_n(rst_n),
      .start_p(start_p), .abort_p(abort_p), .skip_p(skip_p), .pause_p(pause_p),
      .tmr_done(tmr_done),
      .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
      .ld_en(ld_en), .ld_time(ld_time), .run(run),
      .slot_idx(slot_idx), .round_cnt(round_cnt), .buzz(buzz), .busy(busy)
   );

   always #5 clkin = ~clkin;

   int n_chk = 0, n_pass = 0;
   int ld_slot[32], ld_rnd[32];
   logic [15:0] ld_tv[32];

   typedef struct {
      logic [4:0]  in;   // {start, abort, skip, pause, tmr_done}
      logic [25:0] exp;  // {ld_en, ld_time, run, buzz, busy, slot, round}
   } vec_t;
   vec_t vq[$];

   localparam logic [4:0] NO = 5'b00000, ST = 5'b10000, AB = 5'b01000,
                          SK = 5'b00100, PA = 5'b00010, TM = 5'b00001;

   function automatic vec_t mk(input logic [4:0] in, input logic ld, input logic [15:0] t,
                               input logic rn, input logic bz, input logic by,
                               input logic [1:0] sl, input logic [3:0] rc);
      vec_t v;
      v.in  = in;
      v.exp = {ld, t, rn, bz, by, sl, rc};
      return v;
   endfunction

   function automatic logic [25:0] outs();
      return {ld_en, ld_time, run, buzz, busy, slot_idx, round_cnt};
   endfunction

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", nm, act, exp);
   endtask

   task automatic step();
      @(posedge clkin);
      #1;
   endtask

   task automatic cfg_write(input logic [1:0] a, input logic [15:0] d);
      cfg_we = 1'b1; cfg_addr = a; cfg_data = d;
      step();
      cfg_we = 1'b0;
   endtask

   // start, answer every RUN with a tmr_done rise, record each load pulse
   task automatic run_program(input int budget, output int nld, output bit tmo);
      int n;
      nld = 0;
      for (int i = 0; i < 32; i++) begin ld_slot[i] = -1; ld_rnd[i] = -1; ld_tv[i] = '0; end
      start_p = 1'b1; step(); start_p = 1'b0;
      n = 0;
      while (busy && n < budget) begin
         tmr_done = run;
         step();
         n++;
         if (ld_en) begin
            if (nld < 32) begin
               ld_slot[nld] = int'(slot_idx); ld_rnd[nld] = int'(round_cnt); ld_tv[nld] = ld_time;
            end
            nld++;
         end
      end
      tmr_done = 1'b0;
      tmo = (n >= budget);
   endtask

   // start, capture the first load value, then abort back to IDLE
   task automatic first_ld(output logic [15:0] t, output bit got);
      got = 1'b0; t = '0;
      start_p = 1'b1; step(); start_p = 1'b0;
      for (int i = 0; i < 6 && !got; i++) begin
         step();
         if (ld_en) begin got = 1'b1; t = ld_time; end
      end
      abort_p = 1'b1; step(); abort_p = 1'b0;
   endtask

   task automatic start_to_run(output bit ok);
      ok = 1'b0;
      start_p = 1'b1; step(); start_p = 1'b0;
      for (int i = 0; i < 6 && !ok; i++) begin
         step();
         if (run) ok = 1'b1;
      end
   endtask

   initial begin
      int  nld, cnt;
      bit  tmo, got, ok;
      logic [15:0] t;

      #12 rst_n = 1'b1;
      step();
      check("reset_state", {6'b0, outs()}, 32'h0);

      // start -> LOAD -> ld_en -> RUN; tmr_done -> 4 buzz cycles -> slot 1;
      // pause toggles; tmr edge beats pause; skip in BUZZ; abort beats skip
      vq.push_back(mk(ST, 0, 16'h0000, 0, 0, 1, 2'd0, 4'd0));
      vq.push_back(mk(NO, 1, 16'h0500, 0, 0, 1, 2'd0, 4'd0));
      vq.push_back(mk(NO, 0, 16'h0500, 1, 0, 1, 2'd0, 4'd0));
      vq.push_back(mk(NO, 0, 16'h0500, 1, 0, 1, 2'd0, 4'd0));
      vq.push_back(mk(TM, 0, 16'h0500, 0, 1, 1, 2'd0, 4'd0));
      vq.push_back(mk(TM, 0, 16'h0500, 0, 1, 1, 2'd0, 4'd0));
      vq.push_back(mk(NO, 0, 16'h0500, 0, 1, 1, 2'd0, 4'd0));
      vq.push_back(mk(NO, 0, 16'h0500, 0, 1, 1, 2'd0, 4'd0));
      vq.push_back(mk(NO, 0, 16'h0500, 0, 0, 1, 2'd0, 4'd0));
      vq.push_back(mk(NO, 0, 16'h0500, 0, 0, 1, 2'd1, 4'd0));
      vq.push_back(mk(NO, 1, 16'h0100, 0, 0, 1, 2'd1, 4'd0));
      vq.push_back(mk(NO, 0, 16'h0100, 1, 0, 1, 2'd1, 4'd0));
      vq.push_back(mk(PA, 0, 16'h0100, 0, 0, 1, 2'd1, 4'd0));
      vq.push_back(mk(PA, 0, 16'h0100, 1, 0, 1, 2'd1, 4'd0));
      vq.push_back(mk(TM | PA, 0, 16'h0100, 0, 1, 1, 2'd1, 4'd0));
      vq.push_back(mk(SK, 0, 16'h0100, 0, 0, 1, 2'd1, 4'd0));
      vq.push_back(mk(NO, 0, 16'h0100, 0, 0, 1, 2'd2, 4'd0));
      vq.push_back(mk(NO, 1, 16'h0500, 0, 0, 1, 2'd2, 4'd0));
      vq.push_back(mk(NO, 0, 16'h0500, 1, 0, 1, 2'd2, 4'd0));
      vq.push_back(mk(AB | SK, 0, 16'h0500, 0, 0, 0, 2'd2, 4'd0));
      vq.push_back(mk(NO, 0, 16'h0500, 0, 0, 0, 2'd2, 4'd0));
      vq.push_back(mk(NO, 0, 16'h0500, 0, 0, 0, 2'd2, 4'd0));

      foreach (vq[i]) begin
         {start_p, abort_p, skip_p, pause_p, tmr_done} = vq[i].in;
         step();
         check($sformatf("vec%0d", i), {6'b0, outs()}, {6'b0, vq[i].exp});
      end
      {start_p, abort_p, skip_p, pause_p, tmr_done} = NO;

      cnt = 0;
      for (int i = 0; i < 10; i++) begin step(); if (ld_en) cnt++; end
      check("abort_no_ld", cnt, 0);

      // full default program, three rounds of four slots
      run_program(1000, nld, tmo);
      check("full_timeout", tmo, 0);
      check("full_ld_count", nld, 12);
      check("full_end", {busy, slot_idx, round_cnt}, {1'b0, 2'd0, 4'd3});
      check("full_ld5", {ld_slot[4], ld_rnd[4]}, {32'd0, 32'd1});
      check("full_ld4_time", ld_tv[3], 16'h0100);

      // empty slot 2 ends each round after slot 1 (write accepted in DONE)
      cfg_write(2'd2, 16'h0000);
      run_program(1000, nld, tmo);
      check("short_ld_count", {tmo, nld[7:0]}, {1'b0, 8'd6});
      check("short_wrap", {ld_slot[2], ld_rnd[2]}, {32'd0, 32'd1});
      check("short_end", {busy, round_cnt}, {1'b0, 4'd3});

      // write during RUN is dropped
      start_to_run(ok);
      check("reach_run", ok, 1);
      cfg_write(2'd0, 16'h0300);
      abort_p = 1'b1; step(); abort_p = 1'b0;
      check("abort_idle", {busy, run, buzz}, 3'b000);
      first_ld(t, got);
      check("wr_in_run_ignored", {got, t}, {1'b1, 16'h0500});

      // non-BCD digit rejected, valid write accepted
      cfg_write(2'd0, 16'h0A00);
      first_ld(t, got);
      check("bad_bcd_ignored", {got, t}, {1'b1, 16'h0500});
      cfg_write(2'd0, 16'h0230);
      cfg_write(2'd0, 16'h005F);
      first_ld(t, got);
      check("good_wr_taken", {got, t}, {1'b1, 16'h0230});

      // empty slot 0: straight to DONE without a load
      cfg_write(2'd0, 16'h0000);
      run_program(20, nld, tmo);
      check("slot0_empty", {tmo, busy, round_cnt, nld[7:0]}, {1'b0, 1'b0, 4'd0, 8'd0});

      // reset mid-RUN drops run immediately; defaults come back
      cfg_write(2'd0, 16'h0100);
      start_to_run(ok);
      check("reach_run2", ok, 1);
      #2 rst_n = 1'b0;
      #1 check("async_reset", {6'b0, outs()}, 32'h0);
      #3 rst_n = 1'b1;
      cnt = 0;
      for (int i = 0; i < 10; i++) begin step(); if (ld_en) cnt++; end
      check("post_reset_quiet", {busy, cnt[7:0]}, {1'b0, 8'd0});
      first_ld(t, got);
      check("defaults_restored", {got, t}, {1'b1, 16'h0500});

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/timer_sequencer.md
TIMER_SEQUENCER -- requirements
Module: timer_sequencer

Interface
REQ-001 SHALL have parameter NUM_SLOTS, default 4, meaning the number of preset slots.
REQ-002 SHALL have parameter ROUNDS, default 3, meaning program repetitions before DONE.
REQ-003 SHALL have parameter BUZZ_CYC, default 50000000, meaning buzz pulse length in clkin cycles.
REQ-004 SHALL have one clock; reset is asynchronous and active-low: clkin  in  1  system clock; rst_n  in  1  async active-low reset.
REQ-005 SHALL have ports start_p, abort_p, skip_p and pause_p: in, 1 bit each, debounced single-cycle button pulses.
REQ-006 SHALL have port tmr_done  in  1  countdown datapath at 00:00 (level).
REQ-007 SHALL have ports cfg_we  in  1; cfg_addr  in  log2(NUM_SLOTS); cfg_data  in  16  preset write, BCD {min1,min0,sec1,sec0}.
REQ-008 SHALL have port ld_en  out  1  single-cycle load strobe to the datapath.
REQ-009 SHALL have port ld_time  out  16  BCD value to load, valid while ld_en=1.
REQ-010 SHALL have port run  out  1  datapath count enable (0 = stopped).
REQ-011 SHALL have ports slot_idx  out  log2(NUM_SLOTS)  current slot; round_cnt  out  4  completed rounds.
REQ-012 SHALL have ports buzz  out  1  end-of-slot alert; busy  out  1  high outside IDLE/DONE.

Function
REQ-013 SHALL implement the states IDLE, LOAD, SETTLE, RUN, BUZZ, NEXT and DONE; all outputs SHALL be registered.
REQ-014 SHALL, in IDLE or DONE on start_p, clear slot_idx and round_cnt and go to LOAD.
REQ-015 SHALL, in LOAD, go to DONE with no ld_en if slot 0 is 00:00 and slot_idx=0, go to NEXT if slot_idx>0 and the slot is 00:00, and otherwise pulse ld_en for one cycle with ld_time=slot[slot_idx] and go to SETTLE.
REQ-016 SHALL spend exactly one cycle in SETTLE, then enter RUN with run=1.
REQ-017 SHALL, in RUN, act only on the rising edge of tmr_done (registered previous value), then go to BUZZ with run=0.
REQ-018 SHALL, in BUZZ, hold buzz=1 for exactly BUZZ_CYC cycles, then go to NEXT.
REQ-019 SHALL, in NEXT, increment slot_idx and go to LOAD; if slot_idx=NUM_SLOTS-1, or the next slot is 00:00, it SHALL instead set slot_idx=0 and round_cnt+1, then go to DONE if round_cnt+1=ROUNDS, else LOAD.
REQ-020 SHALL, on pause_p in RUN, toggle run; pause_p SHALL be ignored in all other states.
REQ-021 SHALL, on skip_p in RUN or BUZZ, go to NEXT with run=0 and buzz=0 and no buzz.
REQ-022 SHALL, on abort_p in any state, go to IDLE next cycle with run=0, buzz=0 and ld_en=0; slot_idx and round_cnt SHALL be held.
REQ-023 SHALL resolve simultaneous pulses with priority abort_p > skip_p > tmr_done edge > pause_p; a lower-priority event in the same cycle SHALL be dropped.
REQ-024 SHALL accept a cfg_we write only in IDLE or DONE; writes in other states SHALL be ignored, and out-of-range cfg_addr SHALL be ignored.
REQ-025 SHALL never alter the preset table itself on a BCD digit >9 in cfg_data; such a write SHALL be ignored entirely.
REQ-026 SHALL saturate round_cnt at 15 and keep it after DONE until the next start_p.
REQ-027 SHALL drive busy=1 in LOAD, SETTLE, RUN, BUZZ and NEXT.

Reset
REQ-028 SHALL, with rst_n low, asynchronously force IDLE, run=0, ld_en=0, buzz=0, ld_time=0, slot_idx=0 and round_cnt=0.
REQ-029 SHALL, on reset, load preset defaults slot0=05:00, slot1=01:00, slot2=05:00, slot3=01:00 (slots beyond 3 = 00:00).
REQ-030 SHALL, on reset asserted mid-RUN, drop run the same instant; no ld_en SHALL follow release until start_p.

Structure
REQ-031 SHALL place the state enum, BCD time width (16), digit-valid check function and default presets in shared package timer_seq_pkg.
REQ-032 SHALL implement the preset storage, including write-validation and reset defaults, as sub-module seq_preset_table; the FSM SHALL remain in timer_sequencer.

Verification (BUZZ_CYC=4)
REQ-033 SHALL cover: reset, then start_p → ld_en for one cycle with ld_time=0x0500, run=1 two cycles later.
REQ-034 SHALL cover: tmr_done rises in RUN → run=0 and buzz=1 for 4 cycles, then ld_en with ld_time=0x0100 and slot_idx=1.
REQ-035 SHALL cover: ROUNDS=3, four slots completed three times → DONE, round_cnt=3, busy=0, with 12 ld_en pulses total.
REQ-036 SHALL cover: slot2 written 0x0000, run program → after slot1 round_cnt increments and slot_idx returns to 0.
REQ-037 SHALL cover: abort_p and skip_p in the same RUN cycle → IDLE, run=0, no further ld_en.
REQ-038 SHALL cover: cfg_we in RUN, or cfg_data=0x0A00 in IDLE → table unchanged, verified by the next ld_time.
